xb_read32_arbiter: RTL and testbench
====================================

# xb_read32_arbiter

Merges two 24-bit user-logic sample sources into the single Xillybus `read_32` host stream. It sits between the QPSK datapath (for example, TX status and RX samples) and the `user_r_read_32_*` pins of `xillybus_core`. It contains three parts: a round-robin arbiter, a channel-tagging stage and a standard (non-fall-through) FIFO. Stream open/close from the host sequences the block: closing the device file flushes all buffered data and resets sequence numbering.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: log2 of the FIFO depth. Default depth is 16 words; legal range is 2..10.

Ports:
- `bus_clk`  in  1  Xillybus bus clock; every register in the block is clocked by it.
- `bus_rst`  in  1  Asynchronous, active-high reset.
- `src0_valid`  in  1  Source 0 has a word.
- `src0_data`  in  24  Source 0 payload.
- `src0_ready`  out  1  Source 0 word is accepted this cycle.
- `src1_valid`  in  1  Source 1 has a word.
- `src1_data`  in  24  Source 1 payload.
- `src1_ready`  out  1  Source 1 word is accepted this cycle.
- `user_r_read_32_rden`  in  1  Read strobe from the core.
- `user_r_read_32_open`  in  1  Host has the device file open.
- `user_r_read_32_data`  out  32  FIFO read data.
- `user_r_read_32_empty`  out  1  FIFO empty.
- `user_r_read_32_eof`  out  1  Tied to 0.
- `fifo_level`  out  DEPTH_LOG2+1  Current FIFO occupancy.

## Operation
- State machine: `CLOSED` -> `RUN` when `open`=1. `RUN` -> `FLUSH` when `open`=0. `FLUSH` -> `CLOSED` unconditionally after 1 cycle.
- `FLUSH` clears the FIFO pointers and count, both sequence counters and the round-robin pointer.
- `srcN_ready` is asserted only in `RUN`, only when `fifo_level` < 2^DEPTH_LOG2, and only when source N holds the grant.
- Transfer rule: `srcN_valid & srcN_ready` transfers one word. At most one transfer occurs per cycle.
- Arbitration:
  - Only one source valid: it gets the grant.
  - Both valid: the grant goes to the source not served last.
  - Pointer `last` resets to 1, so src0 wins the first tie.
  - `last` updates only on a transfer.
- FIFO word format:
  - [31:30] channel tag (00 = src0, 01 = src1).
  - [29:24] 6-bit per-channel sequence number (see Configuration).
  - [23:0] payload.
- Sequence counters:
  - One counter per channel; each increments on that channel's transfer.
  - Wraps 63 -> 0.
  - Resets to 0 on reset and in `FLUSH`.
- Read side:
  - `rden` with `empty`=0 pops one word.
  - `rden` with `empty`=1 is ignored; data, pointers and count do not change.
- Simultaneous write and read:
  - Count is unchanged and both pointers advance.
  - When full, a same-cycle read does not unblock the write. Ready uses the registered full state.
- Reset values:
  - All ready outputs 0.
  - `user_r_read_32_data` = 0.
  - `user_r_read_32_empty` = 1.
  - `user_r_read_32_eof` = 0.
  - `fifo_level` = 0.
  - State = `CLOSED`.
- Reset asserted mid-operation discards all content immediately, with no drain.

## Timing
- Source handshake to empty:
  - A transfer sampled at edge N increments `fifo_level` at edge N.
  - `empty` deasserts after edge N.
  - Minimum source-to-host latency is 1 cycle.
- Read latency:
  - `rden` sampled at edge N (`empty`=0) registers the word onto `user_r_read_32_data` at edge N.
  - Data stays valid from then until the next pop.
- `empty` and `fifo_level` are registered outputs; `srcN_ready` is combinational from `srcN_valid`, state and the registered count.
- `open` falling at edge N:
  - Ready outputs drop after edge N.
  - FIFO is cleared at edge N+1 (`FLUSH`).
  - `empty`=1 from edge N+1.
- Sustained throughput is 1 word/cycle.
- Two continuously valid sources alternate every cycle.

## Configuration
- Macro: `XB_READ32_ARB_SEQ_EN`.
- Defined: bits [29:24] carry the per-channel sequence number.
- Undefined:
  - Bits [29:24] are 0.
  - The sequence counters are not instantiated.
  - All other behaviour is identical.

## Test plan
- Reset, open=1, src0 pushes 0x000123 once, then rden:
  - empty drops 1 cycle after the push.
  - Data = 0x00000123 (seq 0, tag 00).
  - empty returns to 1.
- Both sources valid continuously, rden=0:
  - Grants alternate src0, src1, ...
  - After 16 transfers, `fifo_level`=16 and both ready=0.
  - Popped tags alternate 00/01, seq 0..7 per channel.
- Full FIFO with rden and both valid in the same cycle:
  - No write that cycle; level = 15 next cycle.
  - Write accepted the following cycle.
- rden while empty:
  - Data, level and empty unchanged.
- 70 src1 words pushed and drained:
  - Seq field wraps 63 -> 0 at word 64 (bits [29:24] = 0x00).
  - With the macro undefined, the field is always 0.
- 5 words buffered, then open 1 -> 0 -> 1:
  - Level = 0, empty = 1.
  - Next src0 word carries seq 0.
  - Ready=0 throughout `FLUSH`/`CLOSED`.

Source files
------------

// File: rtl/xb_read32_arbiter.sv
// xb_read32_arbiter
// Merges two 24-bit sample sources into the Xillybus read_32 host stream.
// A round-robin arbiter feeds a tagging stage and a standard
// (non-fall-through) FIFO.
// Host open/close sequences the block. Closing the device file flushes
// the FIFO and restarts sequence numbering.
// Optional feature: define XB_READ32_ARB_SEQ_EN to carry a 6-bit
// per-channel sequence number in bits [29:24]. Without it those bits are 0.
//
// state   | meaning
// CLOSED  | host not attached, sources held off
// RUN     | sources arbitrated into the FIFO
// FLUSH   | one cycle: clear FIFO, sequence counters and arbiter pointer

module xb_read32_arbiter #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  bus_clk,
    input  logic                  bus_rst,
    input  logic                  src0_valid,
    input  logic [23:0]           src0_data,
    output logic                  src0_ready,
    input  logic                  src1_valid,
    input  logic [23:0]           src1_data,
    output logic                  src1_ready,
    input  logic                  user_r_read_32_rden,
    input  logic                  user_r_read_32_open,
    output logic [31:0]           user_r_read_32_data,
    output logic                  user_r_read_32_empty,
    output logic                  user_r_read_32_eof,
    output logic [DEPTH_LOG2:0]   fifo_level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_RUN    = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t                state_q;
    logic [31:0]           mem_q [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;
    logic [31:0]           rd_data_q;
    logic                  empty_q;
    logic                  last_q;

    logic                  full;
    logic                  run;
    logic                  grant1;
    logic                  push;
    logic                  pop;
    logic                  sel1;
    logic [5:0]            seq_field;
    logic [31:0]           wr_word;

`ifdef XB_READ32_ARB_SEQ_EN
    logic [5:0]            seq0_q;
    logic [5:0]            seq1_q;

    // Per-channel sequence counters, restarted by reset and by a flush.
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            seq0_q <= 6'd0;
            seq1_q <= 6'd0;
        end else if (state_q == ST_FLUSH) begin
            seq0_q <= 6'd0;
            seq1_q <= 6'd0;
        end else begin
            if (src0_ready) seq0_q <= seq0_q + 6'd1;
            if (src1_ready) seq1_q <= seq1_q + 6'd1;
        end
    end

    assign seq_field = sel1 ? seq1_q : seq0_q;
`else
    assign seq_field = 6'd0;
`endif

    // Arbitration and handshake. Full uses only the registered count, so a
    // same-cycle pop never admits a write into a full FIFO.
    always_comb begin
        full       = count_q[DEPTH_LOG2];
        run        = (state_q == ST_RUN);
        grant1     = (src0_valid & src1_valid) ? ~last_q : src1_valid;
        src0_ready = run & ~full & src0_valid & ~grant1;
        src1_ready = run & ~full & src1_valid & grant1;
        push       = src0_ready | src1_ready;
        sel1       = src1_ready;
        pop        = user_r_read_32_rden & ~empty_q;
        wr_word    = {1'b0, sel1, seq_field, sel1 ? src1_data : src0_data};
        case ({push, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; a write lands only while running with room available.
    always_ff @(posedge bus_clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_word;
    end

    // Open/close FSM with registered FIFO control and read-side outputs.
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            state_q   <= ST_CLOSED;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= 32'd0;
            empty_q   <= 1'b1;
            last_q    <= 1'b1;
        end else begin
            if (pop) rd_data_q <= mem_q[rd_ptr_q];

            if (state_q == ST_FLUSH) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                empty_q  <= 1'b1;
                last_q   <= 1'b1;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    last_q   <= sel1;
                end
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_d;
                empty_q <= (count_d == '0);
            end

            case (state_q)
                ST_CLOSED: if (user_r_read_32_open) state_q <= ST_RUN;
                ST_RUN:    if (!user_r_read_32_open) state_q <= ST_FLUSH;
                ST_FLUSH:  state_q <= ST_CLOSED;
                default:   state_q <= ST_CLOSED;
            endcase
        end
    end

    assign user_r_read_32_data  = rd_data_q;
    assign user_r_read_32_empty = empty_q;
    assign user_r_read_32_eof   = 1'b0;
    assign fifo_level           = count_q;

endmodule

// File: tb/tb_xb_read32_arbiter.sv
// Bench for xb_read32_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.

module tb_xb_read32_arbiter;

    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic          bus_clk = 1'b0;
    logic          bus_rst = 1'b1;
    logic          src0_valid = 1'b0;
    logic [23:0]   src0_data = '0;
    logic          src0_ready;
    logic          src1_valid = 1'b0;
    logic [23:0]   src1_data = '0;
    logic          src1_ready;
    logic          rden = 1'b0;
    logic          open = 1'b0;
    logic [31:0]   rd_data;
    logic          empty;
    logic          eof;
    logic [DL:0]   level;

    xb_read32_arbiter #(.DEPTH_LOG2(DL)) dut (
        .bus_clk              (bus_clk),
        .bus_rst              (bus_rst),
        .src0_valid           (src0_valid),
        .src0_data            (src0_data),
        .src0_ready           (src0_ready),
        .src1_valid           (src1_valid),
        .src1_data            (src1_data),
        .src1_ready           (src1_ready),
        .user_r_read_32_rden  (rden),
        .user_r_read_32_open  (open),
        .user_r_read_32_data  (rd_data),
        .user_r_read_32_empty (empty),
        .user_r_read_32_eof   (eof),
        .fifo_level           (level)
    );

    always #5 bus_clk = ~bus_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [5:0] seqf(int v);
`ifdef XB_READ32_ARB_SEQ_EN
        return 6'(v % 64);
`else
        return 6'(v) & 6'd0;
`endif
    endfunction

    // Reference model: queue of stored words, mode 0=closed 1=run 2=flush.
    logic [31:0] mq[$];
    int          mstate;
    int          mlast;
    int          mseq[2];
    logic [31:0] mdata;
    bit          exp_r0, exp_r1;

    task automatic model_ready();
        bit g1;
        bit room;
        room = mq.size() < DEPTH;
        if (src0_valid && src1_valid) g1 = (mlast == 0);
        else g1 = src1_valid;
        exp_r0 = (mstate == 1) && room && src0_valid && !g1;
        exp_r1 = (mstate == 1) && room && src1_valid && g1;
    endtask

    task automatic model_edge();
        logic [31:0] w;
        bit push;
        push = 0;
        w = '0;
        if (exp_r0) begin
            w = {2'b00, seqf(mseq[0]), src0_data};
            push = 1; mlast = 0; mseq[0] = (mseq[0] + 1) % 64;
        end else if (exp_r1) begin
            w = {2'b01, seqf(mseq[1]), src1_data};
            push = 1; mlast = 1; mseq[1] = (mseq[1] + 1) % 64;
        end
        if (rden && mq.size() > 0) mdata = mq.pop_front();
        if (push) mq.push_back(w);
        if (mstate == 2) begin
            mq.delete(); mseq[0] = 0; mseq[1] = 0; mlast = 1;
        end
        case (mstate)
            0:       mstate = open ? 1 : 0;
            1:       mstate = open ? 1 : 2;
            default: mstate = 0;
        endcase
    endtask

    // One clock: check handshake before the edge, registered outputs after.
    task automatic cycle();
        #1;
        model_ready();
        chk("src0_ready", 32'(src0_ready), 32'(exp_r0));
        chk("src1_ready", 32'(src1_ready), 32'(exp_r1));
        model_edge();
        @(posedge bus_clk);
        #1;
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("level", 32'(level), 32'(mq.size()));
        chk("data", rd_data, mdata);
        chk("eof", 32'(eof), 32'd0);
    endtask

    task automatic do_reset();
        bus_rst = 1; src0_valid = 1; src1_valid = 1; rden = 1; open = 1;
        mq.delete(); mstate = 0; mlast = 1; mseq[0] = 0; mseq[1] = 0; mdata = '0;
        @(posedge bus_clk);
        #1;
        chk("rst_src0_ready", 32'(src0_ready), 32'd0);
        chk("rst_src1_ready", 32'(src1_ready), 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_eof", 32'(eof), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        bus_rst = 0; src0_valid = 0; src1_valid = 0; rden = 0; open = 0;
    endtask

    task automatic open_run();
        open = 1;
        cycle();
    endtask

    initial begin
        // Single push then pop.
        do_reset();
        open_run();
        src0_valid = 1; src0_data = 24'h000123;
        cycle();
        chk("t1_empty_after_push", 32'(empty), 32'd0);
        src0_valid = 0; rden = 1;
        cycle();
        chk("t1_data", rd_data, 32'h00000123);
        chk("t1_empty_after_pop", 32'(empty), 32'd1);
        rden = 0;

        // Both valid continuously: alternate grants, fill to 16.
        do_reset();
        open_run();
        src0_valid = 1; src1_valid = 1;
        for (int i = 0; i < 16; i++) begin
            src0_data = 24'($urandom); src1_data = 24'($urandom);
            cycle();
        end
        chk("t2_full_level", 32'(level), 32'd16);
        #1;
        chk("t2_full_r0", 32'(src0_ready), 32'd0);
        chk("t2_full_r1", 32'(src1_ready), 32'd0);

        // Full with rden and both valid: no write this cycle.
        rden = 1;
        cycle();
        chk("t3_level_15", 32'(level), 32'd15);
        chk("t3_first_tag", 32'(rd_data[31:24]), 32'({2'b00, seqf(0)}));
        rden = 0; src0_data = 24'habcdef;
        cycle();
        chk("t3_level_16", 32'(level), 32'd16);
        src0_valid = 0; src1_valid = 0; rden = 1;
        for (int i = 1; i < 16; i++) begin
            cycle();
            chk("t2_drain_tag", 32'(rd_data[31:30]), 32'(i % 2));
            chk("t2_drain_seq", 32'(rd_data[29:24]), 32'(seqf(i / 2)));
        end
        cycle();
        chk("t3_late_word", rd_data, {2'b00, seqf(8), 24'habcdef});

        // rden while empty.
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t4_data_hold", rd_data, {2'b00, seqf(8), 24'habcdef});
            chk("t4_level", 32'(level), 32'd0);
            chk("t4_empty", 32'(empty), 32'd1);
        end
        rden = 0;

        // 70 src1 words streamed through, sequence wrap.
        do_reset();
        open_run();
        rden = 1;
        for (int t = 0; t <= 70; t++) begin
            src1_valid = (t < 70);
            src1_data  = 24'(t);
            cycle();
            if (t >= 1) begin
                chk("t5_seq", 32'(rd_data[29:24]), 32'(seqf(t - 1)));
                chk("t5_payload", 32'(rd_data[23:0]), 32'(t - 1));
                chk("t5_tag", 32'(rd_data[31:30]), 32'd1);
            end
            if (t == 65) chk("t5_seq_wrap", 32'(rd_data[29:24]), 32'd0);
        end
        src1_valid = 0; rden = 0;

        // Buffer 5 words, then close and reopen.
        do_reset();
        open_run();
        src0_valid = 1;
        for (int i = 0; i < 5; i++) begin
            src0_data = 24'(i + 16);
            cycle();
        end
        chk("t6_level5", 32'(level), 32'd5);
        src0_valid = 0; open = 0;
        cycle();
        src0_valid = 1;
        #1;
        chk("t6_flush_ready", 32'(src0_ready), 32'd0);
        cycle();
        chk("t6_level0", 32'(level), 32'd0);
        chk("t6_empty1", 32'(empty), 32'd1);
        #1;
        chk("t6_closed_ready", 32'(src0_ready), 32'd0);
        src0_valid = 0;
        open_run();
        src0_valid = 1; src0_data = 24'h000555;
        cycle();
        src0_valid = 0; rden = 1;
        cycle();
        chk("t6_seq_restart", rd_data, 32'h00000555);
        rden = 0;

        // Randomized traffic with occasional close/reopen and reset.
        do_reset();
        open_run();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                open = 1;
            end
            src0_valid = ($urandom_range(0, 3) != 0);
            src1_valid = ($urandom_range(0, 2) != 0);
            src0_data  = 24'($urandom);
            src1_data  = 24'($urandom);
            rden       = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 59) == 0) open = ~open;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
